// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-product vending controller.
package vend_pkg;

    localparam int DEFAULT_PRICE = 61;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_REFUND  = 2'd3
    } state_e;

    // Index width that stays at least one bit wide for a single-item table.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vend_table.sv
// Per-item price and stock register file with one write port, one decrement
// port and two combinational read ports.
module vend_table #(
    parameter int N_ITEMS       = 8,
    parameter int IDX_W         = 3,
    parameter int CREDIT_W      = 8,
    parameter int STOCK_W       = 4,
    parameter int DEFAULT_PRICE = 61
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en_i,
    input  logic [IDX_W-1:0]    wr_idx_i,
    input  logic [CREDIT_W-1:0] wr_price_i,
    input  logic [STOCK_W-1:0]  wr_stock_i,
    input  logic                dec_en_i,
    input  logic [IDX_W-1:0]    dec_idx_i,
    input  logic [IDX_W-1:0]    rd_a_idx_i,
    output logic [STOCK_W-1:0]  rd_a_stock_o,
    input  logic [IDX_W-1:0]    rd_b_idx_i,
    output logic [CREDIT_W-1:0] rd_b_price_o
);

    logic [CREDIT_W-1:0] price_q [N_ITEMS];
    logic [STOCK_W-1:0]  stock_q [N_ITEMS];

    // Table storage: reset to default price and empty stock, then write or decrement.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                price_q[i] <= CREDIT_W'(DEFAULT_PRICE);
                stock_q[i] <= {STOCK_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
                    price_q[i] <= wr_price_i;
                    stock_q[i] <= wr_stock_i;
                end else if (dec_en_i && (dec_idx_i == IDX_W'(i)) && (stock_q[i] != {STOCK_W{1'b0}})) begin
                    stock_q[i] <= stock_q[i] - STOCK_W'(1);
                end
            end
        end
    end

    assign rd_a_stock_o = stock_q[rd_a_idx_i];
    assign rd_b_price_o = price_q[rd_b_idx_i];

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: coin credit, pending selection, vend with
// exact change, cancel/refund and sold-out detection.
module vend_ctrl_multi #(
    parameter int N_ITEMS       = 8,
    parameter int COIN_W        = 7,
    parameter int CREDIT_W      = 8,
    parameter int STOCK_W       = 4,
    parameter int DEFAULT_PRICE = vend_pkg::DEFAULT_PRICE,
    localparam int IDX_W        = vend_pkg::idx_w(N_ITEMS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_val,
    input  logic                sel_valid,
    input  logic [IDX_W-1:0]    sel_idx,
    input  logic                cancel,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [CREDIT_W-1:0] cfg_price,
    input  logic [STOCK_W-1:0]  cfg_stock,
    output logic                vend_valid,
    output logic [IDX_W-1:0]    vend_idx,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change,
    output logic                add_still,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sold_out
);
    import vend_pkg::*;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                pend_valid_q, pend_valid_d;
    logic [IDX_W-1:0]    pend_idx_q, pend_idx_d;
    logic                vend_valid_q, vend_valid_d;
    logic [IDX_W-1:0]    vend_idx_q, vend_idx_d;
    logic                change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sold_out_q, sold_out_d;

    logic                tbl_we_s, tbl_dec_s;
    logic [STOCK_W-1:0]  sel_stock_s;
    logic [CREDIT_W-1:0] pend_price_s;
    logic                open_s, coin_ok_s, done_s;
    logic [CREDIT_W:0]   coin_sum_s;
    logic [CREDIT_W-1:0] total_s;

    vend_table #(
        .N_ITEMS       (N_ITEMS),
        .IDX_W         (IDX_W),
        .CREDIT_W      (CREDIT_W),
        .STOCK_W       (STOCK_W),
        .DEFAULT_PRICE (DEFAULT_PRICE)
    ) u_table (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (tbl_we_s),
        .wr_idx_i     (cfg_idx),
        .wr_price_i   (cfg_price),
        .wr_stock_i   (cfg_stock),
        .dec_en_i     (tbl_dec_s),
        .dec_idx_i    (vend_idx_q),
        .rd_a_idx_i   (sel_idx),
        .rd_a_stock_o (sel_stock_s),
        .rd_b_idx_i   (pend_idx_q),
        .rd_b_price_o (pend_price_s)
    );

    // The extra sum bit flags a coin that would overflow the credit register.
    assign open_s     = (state_q == S_IDLE) || (state_q == S_COLLECT);
    assign coin_sum_s = {1'b0, credit_q} + {{(CREDIT_W + 1 - COIN_W){1'b0}}, coin_val};
    assign coin_ok_s  = coin_valid && open_s && !coin_sum_s[CREDIT_W];
    assign total_s    = coin_ok_s ? coin_sum_s[CREDIT_W-1:0] : credit_q;
    assign done_s     = (state_q == S_COLLECT) && pend_valid_q && (credit_q >= pend_price_s);

    // Next-state and registered-output decode.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        pend_valid_d   = pend_valid_q;
        pend_idx_d     = pend_idx_q;
        vend_valid_d   = 1'b0;
        vend_idx_d     = vend_idx_q;
        change_valid_d = 1'b0;
        change_d       = change_q;
        coin_reject_d  = coin_valid && !coin_ok_s;
        sold_out_d     = 1'b0;
        tbl_we_s       = 1'b0;
        tbl_dec_s      = 1'b0;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                credit_d = total_s;
                tbl_we_s = cfg_we && (state_q == S_IDLE) && (credit_q == {CREDIT_W{1'b0}});
                if (coin_ok_s) begin
                    state_d = S_COLLECT;
                end else begin
                    state_d = state_q;
                end
                // A coin accepted alongside cancel or completion is folded into the payout.
                if (cancel) begin
                    state_d        = S_REFUND;
                    change_d       = total_s;
                    change_valid_d = 1'b1;
                    credit_d       = {CREDIT_W{1'b0}};
                    pend_valid_d   = 1'b0;
                end else if (done_s) begin
                    state_d        = S_VEND;
                    vend_valid_d   = 1'b1;
                    vend_idx_d     = pend_idx_q;
                    change_d       = total_s - pend_price_s;
                    change_valid_d = 1'b1;
                    credit_d       = {CREDIT_W{1'b0}};
                    pend_valid_d   = 1'b0;
                end else if (sel_valid) begin
                    if (sel_stock_s == {STOCK_W{1'b0}}) begin
                        sold_out_d = 1'b1;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_idx_d   = sel_idx;
                        state_d      = S_COLLECT;
                    end
                end else begin
                    pend_valid_d = pend_valid_q;
                end
            end
            S_VEND: begin
                state_d   = S_IDLE;
                tbl_dec_s = 1'b1;
            end
            S_REFUND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller state and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            credit_q       <= {CREDIT_W{1'b0}};
            pend_valid_q   <= 1'b0;
            pend_idx_q     <= {IDX_W{1'b0}};
            vend_valid_q   <= 1'b0;
            vend_idx_q     <= {IDX_W{1'b0}};
            change_valid_q <= 1'b0;
            change_q       <= {CREDIT_W{1'b0}};
            coin_reject_q  <= 1'b0;
            sold_out_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            pend_valid_q   <= pend_valid_d;
            pend_idx_q     <= pend_idx_d;
            vend_valid_q   <= vend_valid_d;
            vend_idx_q     <= vend_idx_d;
            change_valid_q <= change_valid_d;
            change_q       <= change_d;
            coin_reject_q  <= coin_reject_d;
            sold_out_q     <= sold_out_d;
        end
    end

    assign vend_valid   = vend_valid_q;
    assign vend_idx     = vend_idx_q;
    assign change_valid = change_valid_q;
    assign change       = change_q;
    assign credit       = credit_q;
    assign coin_reject  = coin_reject_q;
    assign sold_out     = sold_out_q;
    assign add_still    = pend_valid_q && (credit_q < pend_price_s);

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_vend_ctrl_multi;

    localparam int CMAX = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cv = 1'b0, sv = 1'b0, can = 1'b0, we = 1'b0;
    logic [6:0] cval = 7'd0;
    logic [2:0] sidx = 3'd0, widx = 3'd0;
    logic [7:0] wp = 8'd0;
    logic [3:0] ws = 4'd0;
    logic       vv, chv, ast, rej, so;
    logic [2:0] vidx;
    logic [7:0] chg, cred;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    vend_ctrl_multi dut (
        .clk(clk), .rst(rst),
        .coin_valid(cv), .coin_val(cval),
        .sel_valid(sv), .sel_idx(sidx), .cancel(can),
        .cfg_we(we), .cfg_idx(widx), .cfg_price(wp), .cfg_stock(ws),
        .vend_valid(vv), .vend_idx(vidx), .change_valid(chv), .change(chg),
        .add_still(ast), .credit(cred), .coin_reject(rej), .sold_out(so)
    );

    always #5 clk = ~clk;

    // Behavioural model: credit in plain integers, pending item as -1/index.
    int m_credit, m_pend, m_vidx;
    int m_price [8];
    int m_stock [8];
    bit m_idle, m_busy, m_vending;
    bit e_vv, e_cv, e_rej, e_so;
    int e_vidx, e_chg;

    always @(posedge clk) begin
        int  tot;
        bit  acc, comp, wr;
        e_vv = 1'b0; e_cv = 1'b0; e_rej = 1'b0; e_so = 1'b0;
        if (!rst) begin
            m_credit = 0; m_pend = -1; m_idle = 1'b1; m_busy = 1'b0; m_vending = 1'b0;
            e_chg = 0;
            for (int i = 0; i < 8; i++) begin
                m_price[i] = 61;
                m_stock[i] = 0;
            end
        end else if (m_busy) begin
            if (m_vending && m_stock[m_vidx] > 0) m_stock[m_vidx] = m_stock[m_vidx] - 1;
            e_rej = cv;
            m_busy = 1'b0; m_vending = 1'b0; m_idle = 1'b1;
        end else begin
            acc  = cv && (m_credit + int'(cval) <= CMAX);
            e_rej = cv && !acc;
            tot  = m_credit + (acc ? int'(cval) : 0);
            comp = (m_pend >= 0) && (m_credit >= m_price[m_pend]);
            wr   = we && m_idle && (m_credit == 0);
            if (acc) m_idle = 1'b0;
            m_credit = tot;
            if (can) begin
                e_cv = 1'b1; e_chg = tot;
                m_credit = 0; m_pend = -1; m_busy = 1'b1;
            end else if (comp) begin
                e_vv = 1'b1; e_vidx = m_pend; e_cv = 1'b1; e_chg = tot - m_price[m_pend];
                m_vidx = m_pend; m_credit = 0; m_pend = -1; m_busy = 1'b1; m_vending = 1'b1;
            end else if (sv) begin
                if (m_stock[sidx] == 0) e_so = 1'b1;
                else begin
                    m_pend = int'(sidx);
                    m_idle = 1'b0;
                end
            end
            if (wr) begin
                m_price[widx] = int'(wp);
                m_stock[widx] = int'(ws);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("vend_valid", int'(vv), int'(e_vv));
            if (e_vv) chk("vend_idx", int'(vidx), e_vidx);
            chk("change_valid", int'(chv), int'(e_cv));
            chk("change", int'(chg), e_chg);
            chk("credit", int'(cred), m_credit);
            chk("coin_reject", int'(rej), int'(e_rej));
            chk("sold_out", int'(so), int'(e_so));
            chk("add_still", int'(ast), int'((m_pend >= 0) && (m_credit < m_price[m_pend])));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cv = 1'b0; sv = 1'b0; can = 1'b0; we = 1'b0;
    endtask

    task automatic coin(input int v);
        cv = 1'b1; cval = 7'(v); tick();
    endtask

    task automatic sel(input int i);
        sv = 1'b1; sidx = 3'(i); tick();
    endtask

    task automatic cfg(input int i, input int p, input int s);
        we = 1'b1; widx = 3'(i); wp = 8'(p); ws = 4'(s); tick();
    endtask

    initial begin
        rst = 1'b0;
        tick(); tick(); tick();
        chk_en = 1'b1;
        chk("rst_credit", int'(cred), 0);
        chk("rst_change", int'(chg), 0);
        chk("rst_vend_valid", int'(vv), 0);
        rst = 1'b1;
        tick();

        // Exact payment on item 2.
        cfg(2, 61, 3);
        chk("cfg_credit", int'(cred), 0);
        coin(50); coin(11);
        chk("exact_credit", int'(cred), 61);
        sel(2);
        chk("exact_add_still", int'(ast), 0);
        tick();
        chk("exact_vend", int'(vv), 1);
        chk("exact_idx", int'(vidx), 2);
        chk("exact_change", int'(chg), 0);
        chk("exact_chv", int'(chv), 1);
        tick();

        // Overpayment with selection first.
        sel(2);
        chk("over_add_still0", int'(ast), 1);
        coin(50);
        chk("over_add_still1", int'(ast), 1);
        coin(50);
        chk("over_add_still2", int'(ast), 0);
        tick();
        chk("over_vend", int'(vv), 1);
        chk("over_change", int'(chg), 39);
        tick();

        // Sold out: empty item, then draining item 2 (one unit left).
        sel(5);
        chk("so_empty", int'(so), 1);
        chk("so_no_pend", int'(ast), 0);
        coin(61); sel(2); tick();
        chk("so_last_vend", int'(vv), 1);
        tick();
        sel(2);
        chk("so_drained", int'(so), 1);
        can = 1'b1; tick(); tick();

        // Overflow rejection, then refund.
        coin(127); coin(123);
        chk("ovf_credit", int'(cred), 250);
        coin(10);
        chk("ovf_reject", int'(rej), 1);
        chk("ovf_keep", int'(cred), 250);
        can = 1'b1; tick();
        chk("ovf_refund", int'(chg), 250);
        chk("ovf_chv", int'(chv), 1);
        tick();

        // Config write with credit present is dropped.
        coin(50);
        cfg(3, 10, 5);
        can = 1'b1; tick();
        chk("blk_refund", int'(chg), 50);
        tick();
        sel(3);
        chk("blk_dropped", int'(so), 1);

        // Reset while in VEND aborts the transaction.
        cfg(4, 20, 2);
        coin(20); sel(4); tick();
        chk("rv_vend", int'(vv), 1);
        rst = 1'b0; tick();
        chk("rv_vv", int'(vv), 0);
        chk("rv_chv", int'(chv), 0);
        chk("rv_chg", int'(chg), 0);
        chk("rv_credit", int'(cred), 0);
        rst = 1'b1; tick();
        sel(4);
        chk("rv_stock_cleared", int'(so), 1);

        // Randomized traffic.
        for (int r = 0; r < 4000; r++) begin
            if (r % 500 == 0) begin
                can = 1'b1; tick(); tick();
                for (int i = 0; i < 8; i++) cfg(i, int'($urandom_range(1, 200)), int'($urandom_range(0, 3)));
            end
            rst  = ($urandom_range(0, 799) != 0);
            cv   = ($urandom_range(0, 2) == 0);
            cval = 7'($urandom_range(1, 127));
            sv   = ($urandom_range(0, 4) == 0);
            sidx = 3'($urandom_range(0, 7));
            can  = ($urandom_range(0, 29) == 0);
            we   = ($urandom_range(0, 19) == 0);
            widx = 3'($urandom_range(0, 7));
            wp   = 8'($urandom_range(1, 255));
            ws   = 4'($urandom_range(0, 4));
            tick();
            rst = 1'b1;
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_multi.md
# vend_ctrl_multi

Parametrised vending-machine controller, successor to the single-product `vmachine2` block. It keeps a per-item price and stock table for `N_ITEMS` products and accumulates coin credit with overflow rejection. It vends a selected item once credit covers its price, returns the exact change, and supports cancel/refund and sold-out detection. It sits between the coin-acceptor and keypad front ends and the dispenser and change-hopper drivers.

## Interface
- `N_ITEMS`, 8 — number of products; `IDX_W = $clog2(N_ITEMS)`
- `COIN_W`, 7 — coin value width
- `CREDIT_W`, 8 — credit, price and change width; must be ≥ `COIN_W`
- `STOCK_W`, 4 — per-item stock counter width
- `DEFAULT_PRICE`, 61 — reset price of every item
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — synchronous, active-low reset
- `coin_valid` in 1 — one-cycle strobe; `coin_val` is inserted
- `coin_val` in `COIN_W` — inserted coin value
- `sel_valid` in 1 — one-cycle strobe; `sel_idx` is selected
- `sel_idx` in `IDX_W` — product index
- `cancel` in 1 — refund request
- `cfg_we` in 1 — table write strobe
- `cfg_idx` in `IDX_W`; `cfg_price` in `CREDIT_W`; `cfg_stock` in `STOCK_W` — table write data
- `vend_valid` out 1 — one-cycle dispense pulse
- `vend_idx` out `IDX_W` — item being dispensed
- `change_valid` out 1 — one-cycle change/refund pulse
- `change` out `CREDIT_W` — change or refund amount, held until the next pulse
- `add_still` out 1 — level; an item is pending and credit < its price
- `credit` out `CREDIT_W` — current credit
- `coin_reject` out 1 — pulse; coin not accepted
- `sold_out` out 1 — pulse; selected item has stock 0

## Operation
- States: IDLE (no credit, nothing pending), COLLECT, VEND (1 cycle), REFUND (1 cycle).
- Coin handling in IDLE or COLLECT:
  - If `credit + coin_val` fits in `CREDIT_W`, credit is added and the state moves to COLLECT.
  - Otherwise `coin_reject` pulses and credit is unchanged.
  - Coins in VEND or REFUND are always rejected.
- Selection handling in IDLE or COLLECT:
  - If stock is 0, `sold_out` pulses and nothing is latched.
  - Otherwise `sel_idx` is latched as pending, replacing any earlier pending item.
  - Selections in VEND or REFUND are ignored.
- COLLECT → VEND at the first edge where an item is pending and `credit >= price[pending]`. In VEND:
  - `vend_valid` = 1 and `vend_idx` = pending item.
  - `change` = credit − price, and `change_valid` = 1 even when change is 0.
  - The item's stock decrements; credit and pending clear.
  - The next state is IDLE.
- `cancel` in IDLE or COLLECT:
  - Go to REFUND, where `change` = credit (including a coin accepted in the same cycle) and `change_valid` = 1.
  - Pending clears and the next state is IDLE.
  - `cancel` in IDLE with zero credit still produces a refund pulse with `change` = 0.
- Priority in one cycle: cancel > completion check > selection; coin acceptance is evaluated independently.
- Table writes: a `cfg_we` write is applied only in IDLE with zero credit; otherwise it is silently dropped.
- `add_still` = pending && `credit < price[pending]`; it is combinational from registers.
- Reset:
  - State is IDLE and credit is 0.
  - All pulses are 0 and `change` is 0.
  - Pending clears.
  - All prices are set to `DEFAULT_PRICE` and all stocks to 0.

## Timing
- All outputs except `add_still` are registered.
- Coin or selection sampled at edge k → credit or pending is updated after k.
  - `coin_reject` / `sold_out` are high in cycle k→k+1.
- The completion check uses the registered credit and pending values, so:
  - The coin or selection that completes payment at edge k gives VEND at edge k+1.
  - `vend_valid` is high for the single cycle after edge k+1.
- `cancel` sampled at edge k → `change_valid` is high in cycle k→k+1.
- Stock decrements at the edge that leaves VEND.
- A new coin is accepted from the cycle after VEND or REFUND.
- Reset mid-VEND aborts the transaction: no stock decrement and no pulse after the reset edge.

## Structure
- Package `vend_pkg`: state enum, `DEFAULT_PRICE`, and the `IDX_W` helper.
- Sub-module `vend_table`: per-item price and stock register file.
  - Ports: config write, one decrement port, combinational read by index for `sel_idx` and the pending item.

## Test plan
- **Reset, then write the table:** write item 2 with price 61 and stock 3 → `credit` = 0 and no pulses.
- **Exact payment:** coin 50, coin 11, select 2 → `vend_valid` with `vend_idx` = 2, `change` = 0 with `change_valid`, stock 2.
- **Overpayment with select first:**
  - Select 2 → `add_still` = 1.
  - Coins 50, 50 → `add_still` = 1 after the first coin.
  - Vend with `change` = 39; `add_still` drops.
- **Sold out:** select an item with stock 0 → `sold_out` pulse, nothing pending; with stock 1, two vends → the second selection gives `sold_out`.
- **Overflow:** credit 250, coin 10 → `coin_reject` and credit stays 250; then `cancel` → `change` = 250, back to IDLE.
- **Blocked config and reset:**
  - `cfg_we` with credit 50 → ignored.
  - Reset asserted in the VEND cycle → no stock decrement, all outputs at reset values.
